// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: step timebase plus four display modes (rotate left/right,
// bounce, blink), mode changes over valid/ready, and level-sensitive pause.
module led_seq_ctrl #(
    parameter int CLK_FREQ = 300_000_000,
    parameter int LED_NUM  = 8,
    parameter int STEP_CYC = 75_000_000
) (
    input  logic               CLK_i,
    input  logic               RSTn_i,
    input  logic [1:0]         MODE_i,
    input  logic               MODE_VLD_i,
    output logic               MODE_RDY_o,
    input  logic               PAUSE_i,
    output logic [LED_NUM-1:0] LED_o,
    output logic [1:0]         MODE_o,
    output logic               STEP_o
);

    localparam int CNT_W = (STEP_CYC > 2) ? $clog2(STEP_CYC) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STEP_CYC - 1);
    localparam logic [LED_NUM-1:0] LED_LSB  = LED_NUM'(1);
    localparam logic [LED_NUM-1:0] LED_MSB  = LED_LSB << (LED_NUM - 1);

    if (CLK_FREQ < 1 || LED_NUM < 2 || STEP_CYC < 2) begin : g_bad_param
        $error("led_seq_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {ROT_L, ROT_R, BOUNCE, BLINK} mode_t;
    typedef enum logic [1:0] {INIT, RUN, PAUSE, LOAD} state_t;

    state_t               state_q, state_nxt;
    mode_t                mode_q, mode_nxt;
    logic [LED_NUM-1:0]   led_q, led_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
    logic                 dir_q, dir_nxt;   // bounce direction, 0 = moving left
    logic                 step_q, step_nxt;
    logic                 rdy_q, rdy_nxt;
    logic                 hs;
    logic                 terminal;

    function automatic logic [LED_NUM-1:0] start_pattern(input mode_t m);
        case (m)
            ROT_L, BOUNCE: start_pattern = LED_LSB;
            ROT_R:         start_pattern = LED_MSB;
            default:       start_pattern = '1;
        endcase
    endfunction

    function automatic logic [LED_NUM-1:0] next_pattern(input mode_t m,
                                                        input logic [LED_NUM-1:0] cur,
                                                        input logic dir);
        case (m)
            ROT_L:   next_pattern = {cur[LED_NUM-2:0], cur[LED_NUM-1]};
            ROT_R:   next_pattern = {cur[0], cur[LED_NUM-1:1]};
            BOUNCE:  next_pattern = dir ? (cur >> 1) : (cur << 1);
            default: next_pattern = ~cur;
        endcase
    endfunction

    // Direction flips on the step that lands on an end, so each end shows once.
    function automatic logic next_dir(input mode_t m,
                                      input logic [LED_NUM-1:0] nxt,
                                      input logic dir);
        next_dir = dir;
        if (m == BOUNCE) begin
            if (!dir && nxt == LED_MSB) next_dir = 1'b1;
            if (dir && nxt == LED_LSB)  next_dir = 1'b0;
        end
    endfunction

    assign hs       = MODE_VLD_i && rdy_q;
    assign terminal = (cnt_q == CNT_LAST);

    always_comb begin
        state_nxt = state_q;
        mode_nxt  = mode_q;
        led_nxt   = led_q;
        cnt_nxt   = cnt_q;
        dir_nxt   = dir_q;
        step_nxt  = 1'b0;
        case (state_q)
            INIT: state_nxt = LOAD;
            LOAD: begin
                state_nxt = PAUSE_i ? PAUSE : RUN;
                led_nxt   = start_pattern(mode_q);
                cnt_nxt   = '0;
                dir_nxt   = 1'b0;
            end
            RUN: begin
                // Handshake beats pause, pause beats a pending step.
                if (hs) begin
                    state_nxt = LOAD;
                    mode_nxt  = mode_t'(MODE_i);
                end else if (PAUSE_i) begin
                    state_nxt = PAUSE;
                end else if (terminal) begin
                    cnt_nxt  = '0;
                    led_nxt  = next_pattern(mode_q, led_q, dir_q);
                    dir_nxt  = next_dir(mode_q, led_nxt, dir_q);
                    step_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            PAUSE: begin
                if (hs) begin
                    state_nxt = LOAD;
                    mode_nxt  = mode_t'(MODE_i);
                end else if (!PAUSE_i) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = INIT;
        endcase
        rdy_nxt = (state_nxt == RUN) || (state_nxt == PAUSE);
    end

    always_ff @(posedge CLK_i) begin
        if (!RSTn_i) begin
            state_q <= INIT;
            mode_q  <= ROT_L;
            led_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            mode_q  <= mode_nxt;
            led_q   <= led_nxt;
            cnt_q   <= cnt_nxt;
            dir_q   <= dir_nxt;
            step_q  <= step_nxt;
            rdy_q   <= rdy_nxt;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RSTn_i) begin
            assert (cnt_q <= CNT_LAST);
        end
    end

    assign LED_o      = led_q;
    assign MODE_o     = mode_q;
    assign STEP_o     = step_q;
    assign MODE_RDY_o = rdy_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with STEP_CYC = 4 and LED_NUM = 8.
module tb_led_seq_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] mode_i;
    logic       vld;
    logic       rdy;
    logic       pause;
    logic [7:0] led;
    logic [1:0] mode_o;
    logic       step;

    int checks = 0;
    int errors = 0;

    led_seq_ctrl #(
        .CLK_FREQ (100_000_000),
        .LED_NUM  (8),
        .STEP_CYC (4)
    ) dut (
        .CLK_i      (clk),
        .RSTn_i     (rstn),
        .MODE_i     (mode_i),
        .MODE_VLD_i (vld),
        .MODE_RDY_o (rdy),
        .PAUSE_i    (pause),
        .LED_o      (led),
        .MODE_o     (mode_o),
        .STEP_o     (step)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] prev, exp;
        rstn = 1'b0; vld = 1'b0; pause = 1'b0; mode_i = 2'd0;
        repeat (3) tick();
        checks++;
        if ({led, mode_o, step, rdy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got led=%h mode=%0d step=%b rdy=%b want all zero", led, mode_o, step, rdy);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if (led !== 8'h00 || rdy !== 1'b0) begin
            errors++;
            $display("FAIL init_edge got led=%h rdy=%b want led=00 rdy=0", led, rdy);
        end
        tick();
        checks++;
        if (led !== 8'h01 || rdy !== 1'b1 || step !== 1'b0) begin
            errors++;
            $display("FAIL first_pattern got led=%h rdy=%b step=%b want led=01 rdy=1 step=0", led, rdy, step);
        end
        exp = 8'h01;
        for (int k = 0; k < 8; k++) begin
            prev = exp;
            exp  = {exp[6:0], exp[7]};
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++;
                if (led !== prev || step !== 1'b0) begin
                    errors++;
                    $display("FAIL rotl_hold got led=%h step=%b want led=%h step=0", led, step, prev);
                end
            end
            tick();
            checks++;
            if (led !== exp || step !== 1'b1) begin
                errors++;
                $display("FAIL rotl_step got led=%h step=%b want led=%h step=1", led, step, exp);
            end
        end
    endtask

    task automatic test_rot_r();
        logic [7:0] prev, exp;
        mode_i = 2'd1; vld = 1'b1;
        tick();
        checks++;
        if (rdy !== 1'b0 || mode_o !== 2'd1 || led !== 8'h01) begin
            errors++;
            $display("FAIL rotr_accept got rdy=%b mode=%0d led=%h want rdy=0 mode=1 led=01", rdy, mode_o, led);
        end
        tick();
        vld = 1'b0;
        checks++;
        if (led !== 8'h80 || rdy !== 1'b1 || step !== 1'b0) begin
            errors++;
            $display("FAIL rotr_load got led=%h rdy=%b step=%b want led=80 rdy=1 step=0", led, rdy, step);
        end
        exp = 8'h80;
        for (int k = 0; k < 8; k++) begin
            prev = exp;
            exp  = {exp[0], exp[7:1]};
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++;
                if (led !== prev || step !== 1'b0) begin
                    errors++;
                    $display("FAIL rotr_hold got led=%h step=%b want led=%h step=0", led, step, prev);
                end
            end
            tick();
            checks++;
            if (led !== exp || step !== 1'b1) begin
                errors++;
                $display("FAIL rotr_step got led=%h step=%b want led=%h step=1", led, step, exp);
            end
        end
    endtask

    task automatic test_bounce(input int nsteps);
        logic [7:0] seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        logic [7:0] prev;
        mode_i = 2'd2; vld = 1'b1;
        tick();
        vld = 1'b0;
        tick();
        checks++;
        if (led !== 8'h01 || mode_o !== 2'd2) begin
            errors++;
            $display("FAIL bounce_load got led=%h mode=%0d want led=01 mode=2", led, mode_o);
        end
        prev = 8'h01;
        for (int k = 0; k < nsteps; k++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++;
                if (led !== prev || step !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce_hold got led=%h step=%b want led=%h step=0", led, step, prev);
                end
            end
            tick();
            checks++;
            if (led !== seq[k] || step !== 1'b1) begin
                errors++;
                $display("FAIL bounce_step%0d got led=%h step=%b want led=%h step=1", k, led, step, seq[k]);
            end
            prev = seq[k];
        end
    endtask

    task automatic test_blink_pause();
        mode_i = 2'd3; vld = 1'b1;
        tick();
        vld = 1'b0;
        tick();
        checks++;
        if (led !== 8'hFF) begin
            errors++;
            $display("FAIL blink_load got led=%h want led=ff", led);
        end
        repeat (4) tick();
        checks++;
        if (led !== 8'h00 || step !== 1'b1) begin
            errors++;
            $display("FAIL blink_toggle got led=%h step=%b want led=00 step=1", led, step);
        end
        // Two counting edges elapse, then the counter is frozen at 2.
        repeat (2) tick();
        pause = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (led !== 8'h00 || step !== 1'b0 || rdy !== 1'b1) begin
                errors++;
                $display("FAIL pause_frozen got led=%h step=%b rdy=%b want led=00 step=0 rdy=1", led, step, rdy);
            end
        end
        pause = 1'b0;
        tick();
        for (int c = 0; c < 1; c++) begin
            tick();
            checks++;
            if (led !== 8'h00 || step !== 1'b0) begin
                errors++;
                $display("FAIL resume_wait got led=%h step=%b want led=00 step=0", led, step);
            end
        end
        tick();
        checks++;
        if (led !== 8'hFF || step !== 1'b1) begin
            errors++;
            $display("FAIL resume_toggle got led=%h step=%b want led=ff step=1", led, step);
        end
        repeat (4) tick();
        checks++;
        if (led !== 8'h00 || step !== 1'b1) begin
            errors++;
            $display("FAIL blink_after_resume got led=%h step=%b want led=00 step=1", led, step);
        end
    endtask

    task automatic test_hs_on_terminal();
        mode_i = 2'd0; vld = 1'b1;
        tick();
        vld = 1'b0;
        tick();
        repeat (12) tick();
        checks++;
        if (led !== 8'h08) begin
            errors++;
            $display("FAIL rotl_reach08 got led=%h want led=08", led);
        end
        repeat (3) tick();
        mode_i = 2'd1; vld = 1'b1;
        tick();
        vld = 1'b0;
        checks++;
        if (led !== 8'h08 || step !== 1'b0 || mode_o !== 2'd1 || rdy !== 1'b0) begin
            errors++;
            $display("FAIL hs_terminal got led=%h step=%b mode=%0d rdy=%b want led=08 step=0 mode=1 rdy=0", led, step, mode_o, rdy);
        end
        tick();
        checks++;
        if (led !== 8'h80 || step !== 1'b0) begin
            errors++;
            $display("FAIL hs_terminal_load got led=%h step=%b want led=80 step=0", led, step);
        end
    endtask

    task automatic test_pause_terminal();
        repeat (3) tick();
        pause = 1'b1;
        tick();
        checks++;
        if (led !== 8'h80 || step !== 1'b0) begin
            errors++;
            $display("FAIL pause_terminal got led=%h step=%b want led=80 step=0", led, step);
        end
        pause = 1'b0;
        tick();
        tick();
        checks++;
        if (led !== 8'h40 || step !== 1'b1) begin
            errors++;
            $display("FAIL resume_terminal got led=%h step=%b want led=40 step=1", led, step);
        end
        pause = 1'b1;
        tick();
        mode_i = 2'd3; vld = 1'b1;
        tick();
        vld = 1'b0;
        checks++;
        if (rdy !== 1'b0 || mode_o !== 2'd3) begin
            errors++;
            $display("FAIL hs_in_pause got rdy=%b mode=%0d want rdy=0 mode=3", rdy, mode_o);
        end
        tick();
        tick();
        checks++;
        if (led !== 8'hFF || rdy !== 1'b1 || step !== 1'b0) begin
            errors++;
            $display("FAIL load_into_pause got led=%h rdy=%b step=%b want led=ff rdy=1 step=0", led, rdy, step);
        end
        pause = 1'b0;
        tick();
        repeat (4) tick();
        checks++;
        if (led !== 8'h00 || step !== 1'b1) begin
            errors++;
            $display("FAIL blink_after_pause got led=%h step=%b want led=00 step=1", led, step);
        end
    endtask

    task automatic test_mid_reset();
        test_bounce(9);
        checks++;
        if (led !== 8'h20) begin
            errors++;
            $display("FAIL bounce_at20 got led=%h want led=20", led);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++;
        if ({led, mode_o, step, rdy} !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset got led=%h mode=%0d step=%b rdy=%b want all zero", led, mode_o, step, rdy);
        end
        tick();
        tick();
        checks++;
        if (led !== 8'h01 || mode_o !== 2'd0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL restart got led=%h mode=%0d rdy=%b want led=01 mode=0 rdy=1", led, mode_o, rdy);
        end
        repeat (4) tick();
        checks++;
        if (led !== 8'h02 || step !== 1'b1) begin
            errors++;
            $display("FAIL restart_step1 got led=%h step=%b want led=02 step=1", led, step);
        end
        repeat (4) tick();
        checks++;
        if (led !== 8'h04 || step !== 1'b1) begin
            errors++;
            $display("FAIL restart_step2 got led=%h step=%b want led=04 step=1", led, step);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rot_r();
        test_bounce(15);
        test_blink_pause();
        test_hs_on_terminal();
        test_pause_terminal();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
